// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// mem_access_unit: byte/half/word load-store stage with read-modify-write.
// Revision: 1.0
// ============================================================================
module mem_access_unit #(
  parameter int ADDR_W = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam logic [1:0] c_size_byte = 2'b00;
  localparam logic [1:0] c_size_half = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [31:0] r_mem_wdata;
  logic        r_err;

  logic        w_accept;
  logic        w_misalign;
  logic [31:0] w_shifted;
  logic [31:0] w_load_data;
  logic [31:0] w_mask;
  logic [31:0] w_lane_data;
  logic [31:0] w_merge_data;

  assign w_accept = req_valid && (r_state == S_IDLE);

  always_comb begin
    w_misalign = 1'b0;
    case (req_size)
      c_size_byte: w_misalign = 1'b0;
      c_size_half: w_misalign = req_addr[0];
      default:     w_misalign = (req_addr[1:0] != 2'b00);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_misalign)                 w_next = S_RESP;
          else if (req_we && req_size[1]) w_next = S_WR;
          else                            w_next = S_RD;
        end
      end
      S_RD:    if (mem_ack) w_next = r_we ? S_WR : S_RESP;
      S_WR:    if (mem_ack) w_next = S_RESP;
      S_RESP:  if (resp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Lane extraction: shifting by 8*addr[1:0] also lands an aligned half in [15:0].
  assign w_shifted = mem_rdata >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_load_data = mem_rdata;
    case (r_size)
      c_size_byte: w_load_data = r_unsigned ? {24'h0, w_shifted[7:0]}
                                            : {{24{w_shifted[7]}}, w_shifted[7:0]};
      c_size_half: w_load_data = r_unsigned ? {16'h0, w_shifted[15:0]}
                                            : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default:     w_load_data = mem_rdata;
    endcase
  end

  always_comb begin
    w_mask      = 32'hFFFF_FFFF;
    w_lane_data = r_wdata;
    case (r_size)
      c_size_byte: begin
        w_mask      = 32'h0000_00FF << {r_addr[1:0], 3'b000};
        w_lane_data = {4{r_wdata[7:0]}};
      end
      c_size_half: begin
        w_mask      = 32'h0000_FFFF << {r_addr[1], 4'b0000};
        w_lane_data = {2{r_wdata[15:0]}};
      end
      default: begin
        w_mask      = 32'hFFFF_FFFF;
        w_lane_data = r_wdata;
      end
    endcase
  end

  assign w_merge_data = (mem_rdata & ~w_mask) | (w_lane_data & w_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we        <= 1'b0;
      r_size      <= 2'b00;
      r_unsigned  <= 1'b0;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_rdata     <= 32'h0;
      r_err       <= 1'b0;
      r_mem_wdata <= 32'h0;
    end else if (w_accept) begin
      r_we        <= req_we;
      r_size      <= req_size;
      r_unsigned  <= req_unsigned;
      r_addr      <= req_addr;
      r_wdata     <= req_wdata;
      r_rdata     <= 32'h0;
      r_err       <= w_misalign;
      // A word store goes straight to WR, so its write word is loaded here.
      r_mem_wdata <= req_wdata;
    end else if ((r_state == S_RD) && mem_ack) begin
      if (r_we) r_mem_wdata <= w_merge_data;
      else      r_rdata     <= w_load_data;
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign mem_req    = (r_state == S_RD) || (r_state == S_WR);
  assign mem_we     = (r_state == S_WR);
  assign mem_addr   = r_addr[ADDR_W+1:2];
  assign mem_wdata  = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// tb_mem_access_unit: directed self-checking bench with a word memory model.
// Revision: 1.0
// ============================================================================
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  mem_access_unit #(.ADDR_W(30)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  // Word memory model: acks after ack_delay cycles of mem_req.
  logic [31:0] mem [0:255];
  int          ack_delay = 0;
  int          wait_cnt = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          req_cycles = 0;
  int          we_cycles = 0;
  logic [29:0] last_wr_addr = '0;
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = 8'h0;
  logic [31:0] pl_data = 32'h0;

  assign mem_ack   = mem_req && (wait_cnt == ack_delay);
  assign mem_rdata = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (mem_req) begin
      req_cycles <= req_cycles + 1;
      if (mem_we) we_cycles <= we_cycles + 1;
    end
    if (mem_req && mem_ack) begin
      wait_cnt <= 0;
      if (mem_we) begin
        mem[mem_addr[7:0]] <= mem_wdata;
        wr_cnt       <= wr_cnt + 1;
        last_wr_addr <= mem_addr;
      end else begin
        rd_cnt <= rd_cnt + 1;
      end
    end else if (mem_req) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    step();
    pl_en   = 1'b0;
  endtask

  task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    step();
    req_valid    = 1'b0;
    req_we       = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_rdata"}, resp_rdata, exp_rdata);
    chk({tag, "_err"}, {31'h0, resp_err}, {31'h0, exp_err});
    step();
    chk({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
  endtask

  initial begin
    int rd0, wr0, rq0, we0, k;

    // Reset state
    step();
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_mem_addr", {2'b00, mem_addr}, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;
    step();

    // Loads from 0x8001_7F00
    preload(8'h10, 32'h8001_7F00);
    preload(8'h11, 32'h5A5A_5A5A);
    we0 = we_cycles;
    do_req("ld_h_s_42", 1'b0, 2'b01, 1'b0, 32'h42, 32'h0, 2, 32'hFFFF_8001, 1'b0);
    chk("ld_h_no_we", 32'(we_cycles - we0), 32'h0);
    do_req("ld_b_u_41", 1'b0, 2'b00, 1'b1, 32'h41, 32'h0, 2, 32'h0000_007F, 1'b0);
    do_req("ld_b_s_43", 1'b0, 2'b00, 1'b0, 32'h43, 32'h0, 2, 32'hFFFF_FF80, 1'b0);
    do_req("ld_b_u_40", 1'b0, 2'b00, 1'b1, 32'h40, 32'h0, 2, 32'h0000_0000, 1'b0);
    do_req("ld_h_u_40", 1'b0, 2'b01, 1'b1, 32'h40, 32'h0, 2, 32'h0000_7F00, 1'b0);
    do_req("ld_w_40", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 2, 32'h8001_7F00, 1'b0);
    do_req("ld_rsv_40", 1'b0, 2'b11, 1'b1, 32'h40, 32'h0, 2, 32'h8001_7F00, 1'b0);

    // Sub-word stores via read-modify-write
    preload(8'h10, 32'h1122_3344);
    rd0 = rd_cnt; wr0 = wr_cnt;
    do_req("st_b_42", 1'b1, 2'b00, 1'b0, 32'h42, 32'hDEAD_BEAB, 3, 32'h0, 1'b0);
    chk("st_b_reads", 32'(rd_cnt - rd0), 32'h1);
    chk("st_b_writes", 32'(wr_cnt - wr0), 32'h1);
    chk("st_b_waddr", {2'b00, last_wr_addr}, 32'h10);
    chk("st_b_mem", mem[8'h10], 32'h11AB_3344);
    do_req("st_h_42", 1'b1, 2'b01, 1'b0, 32'h42, 32'hFFFF_5566, 3, 32'h0, 1'b0);
    chk("st_h_mem", mem[8'h10], 32'h5566_3344);
    do_req("st_w_44", 1'b1, 2'b10, 1'b0, 32'h44, 32'h0BAD_F00D, 2, 32'h0, 1'b0);
    chk("st_w_mem", mem[8'h11], 32'h0BAD_F00D);

    // Misaligned accesses
    rq0 = req_cycles;
    do_req("st_w_46", 1'b1, 2'b10, 1'b0, 32'h46, 32'h1234_5678, 1, 32'h0, 1'b1);
    do_req("ld_h_41", 1'b0, 2'b01, 1'b0, 32'h41, 32'h0, 1, 32'h0, 1'b1);
    chk("mis_no_memreq", 32'(req_cycles - rq0), 32'h0);
    chk("mis_mem_unch", mem[8'h11], 32'h0BAD_F00D);

    // Late ack and stalled response
    preload(8'h20, 32'hCAFE_BABE);
    ack_delay  = 3;
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h80; req_wdata = 32'h0;
    step();
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFC; req_we = 1'b1;
    k = 0;
    while (mem_req && k < 20) begin
      chk("late_addr", {2'b00, mem_addr}, 32'h20);
      chk("late_we", {31'h0, mem_we}, 32'h0);
      step();
      k++;
    end
    chk("late_req_cycles", 32'(k), 32'h4);
    for (int i = 0; i < 4; i++) begin
      chk("hold_valid", {31'h0, resp_valid}, 32'h1);
      chk("hold_rdata", resp_rdata, 32'hCAFE_BABE);
      chk("hold_ready", {31'h0, req_ready}, 32'h0);
      step();
    end
    resp_ready = 1'b1;
    #1;
    chk("rel_ready_same", {31'h0, req_ready}, 32'h0);
    step();
    chk("rel_ready_next", {31'h0, req_ready}, 32'h1);
    chk("rel_valid_next", {31'h0, resp_valid}, 32'h0);

    // Reset during the read phase of a sub-word store
    preload(8'h12, 32'h0102_0304);
    ack_delay = 5;
    wr0 = wr_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h48; req_wdata = 32'h0000_00EE;
    step();
    req_valid = 1'b0;
    chk("abort_rd_req", {31'h0, mem_req}, 32'h1);
    step();
    rst_n = 1'b0;
    #1;
    chk("abort_req_low", {31'h0, mem_req}, 32'h0);
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("abort_ready", {31'h0, req_ready}, 32'h1);
    chk("abort_no_write", 32'(wr_cnt - wr0), 32'h0);
    chk("abort_mem_unch", mem[8'h12], 32'h0102_0304);
    ack_delay = 0;
    do_req("post_ld_w", 1'b0, 2'b10, 1'b0, 32'h48, 32'h0, 2, 32'h0102_0304, 1'b0);
    chk("post_no_write", 32'(wr_cnt - wr0), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
